// File: rtl/i2s_tx_serializer_if.sv
// rtl/i2s_tx_serializer_if.sv - sample input and serial output bundle of the I2S transmitter
interface i2s_tx_serializer_if #(
    parameter int BIT_WIDTH = 24
);
    logic                 enable;
    logic [BIT_WIDTH-1:0] left_in;
    logic [BIT_WIDTH-1:0] right_in;
    logic                 sample_req;
    logic                 bclk;
    logic                 lrclk;
    logic                 sdata;

    modport master (
        output enable, left_in, right_in,
        input  sample_req, bclk, lrclk, sdata
    );

    modport slave (
        input  enable, left_in, right_in,
        output sample_req, bclk, lrclk, sdata
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - stereo I2S transmitter: latches L/R sample pairs and serializes them MSB first
module i2s_tx_serializer #(
    parameter int BIT_WIDTH = 24,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic               clk,
    input  logic               reset,
    i2s_tx_serializer_if.slave bus
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int PAD_BITS   = SLOT_BITS - BIT_WIDTH;
    localparam int PW         = $clog2(FRAME_BITS);
    localparam int DW         = $clog2(BCLK_DIV);

    localparam logic [PW-1:0] P_LAST   = PW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] P_LR_LO  = PW'(SLOT_BITS - 1);
    localparam logic [PW-1:0] P_LR_HI  = PW'(FRAME_BITS - 2);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [PW-1:0]         p_q, p_d;
    logic [BIT_WIDTH-1:0]  left_hold, right_hold;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  bclk_q, lrclk_q, sdata_q, sample_req_q;
    logic                  bclk_d, lrclk_d, sdata_d, sample_req_d;

    // Whole frame laid out MSB first: position p maps to bit FRAME_BITS-1-p.
    assign frame_word = {left_hold, {PAD_BITS{1'b0}}, right_hold, {PAD_BITS{1'b0}}};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        p_d     = p_q;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            div_d   = '0;
            p_d     = P_LAST;
        end else if (state_q == ST_IDLE) begin
            // First enabled cycle keeps the idle counters: that position is the latch slot.
            state_d = ST_RUN;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            p_d   = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        end else begin
            div_d = div_q + DW'(1);
        end

        // Outputs are registered from the next counter state so they line up with it.
        sample_req_d = bus.enable && (p_d == P_LAST) && (div_d == '0);
        bclk_d       = bus.enable && (div_d >= DIV_HALF);
        lrclk_d      = bus.enable && (p_d >= P_LR_LO) && (p_d <= P_LR_HI);
        sdata_d      = bus.enable && frame_word[P_LAST - p_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            p_q          <= P_LAST;
            left_hold    <= '0;
            right_hold   <= '0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            sample_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            p_q          <= p_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            sample_req_q <= sample_req_d;
            if (sample_req_q && bus.enable) begin
                left_hold  <= bus.left_in;
                right_hold <= bus.right_in;
            end
        end
    end

    assign bus.sample_req = sample_req_q;
    assign bus.bclk       = bclk_q;
    assign bus.lrclk      = lrclk_q;
    assign bus.sdata      = sdata_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - randomized self-checking bench for i2s_tx_serializer against a frame-timing model
module tb_i2s_tx_serializer;
    localparam int BW  = 24;
    localparam int A_S = 32;
    localparam int A_D = 4;
    localparam int B_S = 25;
    localparam int B_D = 2;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    i2s_tx_serializer_if #(.BIT_WIDTH(BW)) bus_a ();
    i2s_tx_serializer_if #(.BIT_WIDTH(BW)) bus_b ();

    i2s_tx_serializer #(.BIT_WIDTH(BW), .SLOT_BITS(A_S), .BCLK_DIV(A_D)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    i2s_tx_serializer #(.BIT_WIDTH(BW), .SLOT_BITS(B_S), .BCLK_DIV(B_D)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs(input bit sel);
        if (sel) return {bus_b.sample_req, bus_b.bclk, bus_b.lrclk, bus_b.sdata};
        return {bus_a.sample_req, bus_a.bclk, bus_a.lrclk, bus_a.sdata};
    endfunction

    // Expected {sample_req, bclk, lrclk, sdata} at t cycles after a sample_req pulse.
    function automatic logic [3:0] model_out(input int t, input int s, input int d,
                                             input logic [BW-1:0] l, input logic [BW-1:0] r);
        int k;
        int p;
        logic sd;
        logic [BW-1:0] w;
        k  = t / d;
        p  = (k == 0) ? 2 * s - 1 : k - 1;
        sd = 1'b0;
        if (p < BW) begin
            w  = l >> (BW - 1 - p);
            sd = w[0];
        end else if (p >= s && p < s + BW) begin
            w  = r >> (BW - 1 - (p - s));
            sd = w[0];
        end
        return {t == 0, (t % d) >= d / 2, (p >= s - 1) && (p <= 2 * s - 2), sd};
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic [BW-1:0] li,
                              input logic [BW-1:0] ri, input int s, input int d,
                              inout int t, inout bit run, inout logic [BW-1:0] l,
                              inout logic [BW-1:0] r, output logic [3:0] e);
        if (rst) begin
            run = 1'b0; t = 0; l = '0; r = '0;
        end else if (!en) begin
            run = 1'b0; t = 0;
        end else begin
            if (run && t == 0) begin
                l = li; r = ri;
            end
            t   = run ? (t + 1) % (2 * s * d) : 0;
            run = 1'b1;
        end
        e = run ? model_out(t, s, d, l, r) : 4'b0;
    endtask

    int            ma_t = 0, mb_t = 0;
    bit            ma_run = 1'b0, mb_run = 1'b0;
    logic [BW-1:0] ma_l = '0, ma_r = '0, mb_l = '0, mb_r = '0;

    initial forever begin
        logic [3:0] e;
        @(posedge clk);
        model_step(reset, bus_a.enable, bus_a.left_in, bus_a.right_in, A_S, A_D,
                   ma_t, ma_run, ma_l, ma_r, e);
        #1;
        check_eq("mon_a", 64'(outs(0)), 64'(e));
    end

    initial forever begin
        logic [3:0] e;
        @(posedge clk);
        model_step(reset, bus_b.enable, bus_b.left_in, bus_b.right_in, B_S, B_D,
                   mb_t, mb_run, mb_l, mb_r, e);
        #1;
        check_eq("mon_b", 64'(outs(1)), 64'(e));
    end

    // Called in a sample_req cycle; bit p of the frame goes to bits[p], read on bclk rising edges.
    task automatic capture(input bit sel, input int s, input int d,
                           output logic [63:0] bits, output logic [63:0] lr,
                           output int period, output int lr_rise, output logic msb);
        logic [3:0] o;
        logic prev_bclk;
        int   rises;
        bits = '0; lr = '0; period = -1; lr_rise = -1; msb = 1'b0; rises = 0;
        o = outs(sel);
        prev_bclk = o[2];
        for (int c = 1; c <= 6 * s * d; c++) begin
            @(posedge clk);
            #1;
            o = outs(sel);
            if (o[2] && !prev_bclk) begin
                if (rises >= 1) begin
                    bits = bits | (64'(o[0]) << (rises - 1));
                    lr   = lr   | (64'(o[1]) << (rises - 1));
                end
                rises++;
            end
            prev_bclk = o[2];
            if (c == d) msb = o[0];
            if (lr_rise < 0 && o[1]) lr_rise = c;
            if (period < 0 && o[3]) period = c;
            if (rises > 2 * s) break;
        end
        check_eq("capture_bits", 64'(rises), 64'(2 * s + 1));
    endtask

    task automatic wait_pulse(input bit sel, input int budget);
        logic [3:0] o;
        o = outs(sel);
        for (int n = 0; n < budget && !o[3]; n++) begin
            @(posedge clk);
            #1;
            o = outs(sel);
        end
        check_eq("pulse_seen", 64'(o[3]), 64'd1);
    endtask

    function automatic logic [31:0] slot_word(input logic [63:0] b, input int base, input int s);
        logic [31:0] w;
        logic [63:0] tmp;
        w = '0;
        for (int k = 0; k < s; k++) begin
            tmp = b >> (base + k);
            w   = {w[30:0], tmp[0]};
        end
        return w;
    endfunction

    logic [63:0]   bits_a, lr_a, bits_b, lr_b;
    int            per_a, rise_a, per_b, rise_b;
    logic          msb_a, msb_b;
    logic [BW-1:0] l_b0, r_b0, l_new, r_new;

    initial begin
        reset          = 1'b1;
        bus_a.enable   = 1'b1;
        bus_a.left_in  = 24'h800001;
        bus_a.right_in = 24'h7FFFFE;
        l_b0           = 24'($urandom);
        r_b0           = 24'($urandom);
        bus_b.enable   = 1'b1;
        bus_b.left_in  = l_b0;
        bus_b.right_in = r_b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("reset_outs_a", 64'(outs(0)), 64'd0);
        check_eq("reset_outs_b", 64'(outs(1)), 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("first_req_a", 64'(bus_a.sample_req), 64'd1);
        check_eq("first_req_b", 64'(bus_b.sample_req), 64'd1);

        fork
            capture(1'b0, A_S, A_D, bits_a, lr_a, per_a, rise_a, msb_a);
            capture(1'b1, B_S, B_D, bits_b, lr_b, per_b, rise_b, msb_b);
        join
        check_eq("left_word_a",  64'(slot_word(bits_a, 0, A_S)),  64'h80000100);
        check_eq("right_word_a", 64'(slot_word(bits_a, A_S, A_S)), 64'h7FFFFE00);
        check_eq("lrclk_map_a",  lr_a, 64'h7FFF_FFFF_8000_0000);
        check_eq("period_a",     64'(per_a), 64'd256);
        check_eq("left_msb_a",   64'(msb_a), 64'd1);
        check_eq("lrclk_rise_a", 64'(rise_a), 64'(A_S * A_D));
        check_eq("period_b",     64'(per_b), 64'd100);
        check_eq("left_word_b",  64'(slot_word(bits_b, 0, B_S)),   64'({l_b0, 1'b0}));
        check_eq("right_word_b", 64'(slot_word(bits_b, B_S, B_S)), 64'({r_b0, 1'b0}));
        check_eq("right_lsb_b",  64'(bits_b[48]), 64'(r_b0[0]));
        check_eq("pad_bit_b",    64'(bits_b[49]), 64'd0);
        check_eq("pad_lrclk_b",  64'(lr_b[49]), 64'd0);
        check_eq("lrclk_map_b",  lr_b, 64'h0001_FFFF_FF00_0000);
        check_eq("left_msb_b",   64'(msb_b), 64'(l_b0[BW-1]));

        // A mid-frame input change must not reach the frame already latched.
        wait_pulse(1'b0, 600);
        fork
            capture(1'b0, A_S, A_D, bits_a, lr_a, per_a, rise_a, msb_a);
            begin
                repeat (60) @(negedge clk);
                bus_a.left_in = 24'h123456;
            end
        join
        check_eq("isolate_cur_a", 64'(slot_word(bits_a, 0, A_S)), 64'h80000100);
        wait_pulse(1'b0, 600);
        capture(1'b0, A_S, A_D, bits_a, lr_a, per_a, rise_a, msb_a);
        check_eq("isolate_next_a", 64'(slot_word(bits_a, 0, A_S)),   64'h12345600);
        check_eq("isolate_right_a", 64'(slot_word(bits_a, A_S, A_S)), 64'h7FFFFE00);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(40, 200)) @(negedge clk);
            bus_a.left_in  = 24'($urandom);
            bus_a.right_in = 24'($urandom);
            bus_b.left_in  = 24'($urandom);
            bus_b.right_in = 24'($urandom);
        end

        wait_pulse(1'b0, 600);
        repeat (140) @(posedge clk);
        @(negedge clk);
        l_new          = 24'($urandom);
        r_new          = 24'($urandom);
        bus_a.enable   = 1'b0;
        bus_a.left_in  = l_new;
        bus_a.right_in = r_new;
        @(posedge clk);
        #1;
        check_eq("drop_outs_a", 64'(outs(0)), 64'd0);
        repeat (5) @(negedge clk);
        bus_a.enable = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reenable_req_a", 64'(bus_a.sample_req), 64'd1);
        capture(1'b0, A_S, A_D, bits_a, lr_a, per_a, rise_a, msb_a);
        check_eq("reenable_left_a",  64'(slot_word(bits_a, 0, A_S)),   64'({l_new, 8'h00}));
        check_eq("reenable_right_a", 64'(slot_word(bits_a, A_S, A_S)), 64'({r_new, 8'h00}));
        check_eq("reenable_period_a", 64'(per_a), 64'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
